pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong sequencer: serve/play/pause/point/game-over flow,
// per-player scoring and winner latch, all timed in frames via fsync.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for first start press, ball held, paddles locked
// SERVE    | ball held at centre for SERVE_FRAMES, paddles free
// PLAY     | ball in motion, misses score points
// PAUSE    | everything frozen until the next start press
// POINT    | freeze for POINT_FRAMES after a point, then serve or end
// GAMEOVER | a player reached WIN_SCORE, winner valid, start begins a new game
module pong_game_ctrl #(
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 7
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       fsync,
    input  logic       start_btn,
    input  logic       miss_top,
    input  logic       miss_bot,
    output logic       paddle_en,
    output logic       ball_rst,
    output logic       ball_freeze,
    output logic       serve_dir,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        PAUSE    = 3'd3,
        POINT    = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES);
    localparam logic [3:0] WIN_LIM    = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] frame_cnt, frame_cnt_d;
    logic [3:0] score_one_d, score_two_d;
    logic       serve_dir_d, winner_d;
    logic       sync_a, sync_b, sync_c, start_edge;
    logic       frame_done;

    // two-flop synchronizer, then a registered rising-edge pulse
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            sync_c     <= 1'b0;
            start_edge <= 1'b0;
        end else begin
            sync_a     <= start_btn;
            sync_b     <= sync_a;
            sync_c     <= sync_b;
            start_edge <= sync_b & ~sync_c;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_cnt <= 8'd0;
            score_one <= 4'd0;
            score_two <= 4'd0;
            serve_dir <= 1'b1;
            winner    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_cnt <= frame_cnt_d;
            score_one <= score_one_d;
            score_two <= score_two_d;
            serve_dir <= serve_dir_d;
            winner    <= winner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_one_d = score_one;
        score_two_d = score_two;
        serve_dir_d = serve_dir;
        winner_d    = winner;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) state_d = SERVE;
            end
            SERVE: begin
                if (fsync && (frame_cnt + 8'd1 == SERVE_LAST)) state_d = PLAY;
            end
            PLAY: begin
                // miss_top has priority over miss_bot, and any miss over start
                if (miss_top) begin
                    if (score_two < WIN_LIM) score_two_d = score_two + 4'd1;
                    serve_dir_d = 1'b0;
                    state_d     = POINT;
                end else if (miss_bot) begin
                    if (score_one < WIN_LIM) score_one_d = score_one + 4'd1;
                    serve_dir_d = 1'b1;
                    state_d     = POINT;
                end else if (start_edge) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start_edge) state_d = PLAY;
            end
            POINT: begin
                frame_done = fsync && (frame_cnt + 8'd1 == POINT_LAST);
                if (frame_done) begin
                    if (score_one == WIN_LIM || score_two == WIN_LIM) begin
                        state_d  = GAMEOVER;
                        winner_d = (score_two == WIN_LIM);
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            GAMEOVER: begin
                if (start_edge) begin
                    state_d     = SERVE;
                    score_one_d = 4'd0;
                    score_two_d = 4'd0;
                    serve_dir_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            frame_cnt_d = 8'd0;
        else if (fsync && (state_q == SERVE || state_q == POINT))
            frame_cnt_d = frame_cnt + 8'd1;
        else
            frame_cnt_d = frame_cnt;
    end

    always_comb begin
        paddle_en   = 1'b0;
        ball_rst    = 1'b1;
        ball_freeze = 1'b1;
        game_over   = 1'b0;
        case (state_q)
            SERVE: begin
                paddle_en   = 1'b1;
                ball_freeze = 1'b0;
            end
            PLAY: begin
                paddle_en   = 1'b1;
                ball_rst    = 1'b0;
                ball_freeze = 1'b0;
            end
            PAUSE:    ball_rst  = 1'b0;
            GAMEOVER: game_over = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: expected states/scores are queued
// as each stimulus is applied and compared against the DUT at the falling edge.
module tb_pong_game_ctrl;

    localparam int SF = 4;
    localparam int PF = 2;
    localparam int WS = 3;

    logic       pixel_clk = 1'b0;
    logic       rst, fsync, start_btn, miss_top, miss_bot;
    logic       paddle_en, ball_rst, ball_freeze, serve_dir, game_over, winner;
    logic [3:0] score_one, score_two;
    logic [2:0] state;

    pong_game_ctrl #(.SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WS)) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .fsync      (fsync),
        .start_btn  (start_btn),
        .miss_top   (miss_top),
        .miss_bot   (miss_bot),
        .paddle_en  (paddle_en),
        .ball_rst   (ball_rst),
        .ball_freeze(ball_freeze),
        .serve_dir  (serve_dir),
        .score_one  (score_one),
        .score_two  (score_two),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [2:0] st;
        logic       pe;
        logic       br;
        logic       bf;
        logic       go;
    } dec_t;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       dir;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       chk_win;
        logic       win;
    } exp_t;

    dec_t dec_tbl [6];
    exp_t sb_q [$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_PAUSE = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;

    // one clock: inputs change 1 time unit after the edge, pulses self-clear
    task automatic step();
        @(posedge pixel_clk);
        #1;
        cyc++;
        fsync    = (cyc % 100 == 0);
        miss_top = 1'b0;
        miss_bot = 1'b0;
    endtask

    task automatic wait_fsync(input int n);
        for (int i = 0; i < n; i++) begin
            logic f;
            int   guard;
            guard = 0;
            do begin
                f = fsync;
                step();
                guard++;
            end while (!f && guard < 250);
            if (!f) begin
                $display("FAIL fsync_wait: no fsync after %0d cycles, need one", guard);
                bad++;
                total++;
            end
        end
    endtask

    task automatic press();
        start_btn = 1'b0;
        repeat (3) step();
        start_btn = 1'b1;
        repeat (4) step();
        start_btn = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [2:0] st, input logic dir,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic chk_win, input logic win);
        exp_t e;
        e.name = name; e.st = st; e.dir = dir; e.s1 = s1; e.s2 = s2;
        e.chk_win = chk_win; e.win = win;
        sb_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        dec_t d;
        logic ok;
        @(negedge pixel_clk);
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            d  = dec_tbl[e.st];
            ok = (state === e.st) && (paddle_en === d.pe) && (ball_rst === d.br) &&
                 (ball_freeze === d.bf) && (game_over === d.go) && (serve_dir === e.dir) &&
                 (score_one === e.s1) && (score_two === e.s2) &&
                 (!e.chk_win || winner === e.win);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s: got st=%0d pe=%b br=%b bf=%b go=%b dir=%b s1=%0d s2=%0d win=%b, need st=%0d pe=%b br=%b bf=%b go=%b dir=%b s1=%0d s2=%0d win=%b",
                         e.name, state, paddle_en, ball_rst, ball_freeze, game_over, serve_dir,
                         score_one, score_two, winner, e.st, d.pe, d.br, d.bf, d.go, e.dir,
                         e.s1, e.s2, e.chk_win ? e.win : winner);
            end
        end
    endtask

    initial begin
        dec_tbl[0] = '{S_IDLE,  1'b0, 1'b1, 1'b1, 1'b0};
        dec_tbl[1] = '{S_SERVE, 1'b1, 1'b1, 1'b0, 1'b0};
        dec_tbl[2] = '{S_PLAY,  1'b1, 1'b0, 1'b0, 1'b0};
        dec_tbl[3] = '{S_PAUSE, 1'b0, 1'b0, 1'b1, 1'b0};
        dec_tbl[4] = '{S_POINT, 1'b0, 1'b1, 1'b1, 1'b0};
        dec_tbl[5] = '{S_OVER,  1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; fsync = 1'b0; start_btn = 1'b0; miss_top = 1'b0; miss_bot = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        expect_out("reset", S_IDLE, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0); check();

        // start edge lands three cycles after the raw rise, SERVE one cycle later
        start_btn = 1'b1;
        repeat (3) step();
        expect_out("idle_before_edge", S_IDLE, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0); check();
        step();
        start_btn = 1'b0;
        expect_out("serve_entry", S_SERVE, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0); check();
        wait_fsync(SF - 1);
        expect_out("serve_hold", S_SERVE, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0); check();
        wait_fsync(1);
        expect_out("serve_release", S_PLAY, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0); check();

        miss_bot = 1'b1; step();
        expect_out("miss_bot", S_POINT, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); check();
        miss_top = 1'b1; step();
        expect_out("point_ignores_miss", S_POINT, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); check();
        wait_fsync(PF - 1);
        expect_out("point_hold", S_POINT, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); check();
        wait_fsync(1);
        expect_out("point_to_serve", S_SERVE, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); check();
        miss_top = 1'b1; step();
        expect_out("serve_ignores_miss", S_SERVE, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); check();
        wait_fsync(SF);
        expect_out("play_again", S_PLAY, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); check();

        miss_top = 1'b1; miss_bot = 1'b1; step();
        expect_out("double_miss", S_POINT, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0); check();
        wait_fsync(PF);
        expect_out("serve_up", S_SERVE, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0); check();
        wait_fsync(SF);
        expect_out("play_3", S_PLAY, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0); check();

        press();
        expect_out("pause", S_PAUSE, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0); check();
        miss_top = 1'b1; step();
        expect_out("pause_ignores_miss", S_PAUSE, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0); check();
        press();
        expect_out("resume", S_PLAY, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0); check();

        // miss arriving in the same cycle as fsync
        for (int g = 0; g < 200 && !fsync; g++) step();
        miss_top = 1'b1; step();
        expect_out("miss_with_fsync", S_POINT, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0); check();
        wait_fsync(PF);
        wait_fsync(SF);
        expect_out("play_4", S_PLAY, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0); check();
        miss_top = 1'b1; step();
        expect_out("winning_point", S_POINT, 1'b0, 4'd1, 4'd3, 1'b0, 1'b0); check();
        wait_fsync(PF - 1);
        expect_out("winning_point_hold", S_POINT, 1'b0, 4'd1, 4'd3, 1'b0, 1'b0); check();
        wait_fsync(1);
        expect_out("game_over", S_OVER, 1'b0, 4'd1, 4'd3, 1'b1, 1'b1); check();
        miss_bot = 1'b1; step();
        miss_top = 1'b1; step();
        expect_out("over_ignores_miss", S_OVER, 1'b0, 4'd1, 4'd3, 1'b1, 1'b1); check();
        press();
        expect_out("new_game", S_SERVE, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0); check();
        wait_fsync(SF);
        expect_out("play_5", S_PLAY, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0); check();

        // start edge and miss on the same clock: the miss wins
        start_btn = 1'b0;
        repeat (3) step();
        start_btn = 1'b1;
        repeat (3) step();
        miss_bot = 1'b1; step();
        start_btn = 1'b0;
        expect_out("miss_beats_start", S_POINT, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0); check();
        wait_fsync(PF);
        wait_fsync(SF);
        miss_bot = 1'b1; step();
        wait_fsync(1);
        expect_out("point_mid_count", S_POINT, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0); check();
        rst = 1'b1; step();
        expect_out("reset_mid_point", S_IDLE, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0); check();
        rst = 1'b0; step();
        expect_out("idle_after_reset", S_IDLE, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0); check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
